// File: rtl/gm_pkg.sv
// gm_pkg: shared constants and types for the graphic manager write path.
//   COL_NUM/ROW_NUM/PIXEL_NUM : screen geometry (320 x 240 b/w pixels)
//   COL_WIDTH/ROW_WIDTH       : coordinate bus widths
//   arb_state_t               : write arbiter states IDLE / OWN0 / OWN1
//   pixel_in_range()          : true when a coordinate lies on the screen
package gm_pkg;

    localparam int COL_NUM   = 320;
    localparam int ROW_NUM   = 240;
    localparam int PIXEL_NUM = 76800;
    localparam int COL_WIDTH = 9;
    localparam int ROW_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic pixel_in_range(input logic [COL_WIDTH-1:0] col,
                                            input logic [ROW_WIDTH-1:0] row);
        return (col < COL_WIDTH'(COL_NUM)) && (row < ROW_WIDTH'(ROW_NUM));
    endfunction

endpackage

// File: rtl/gm_write_arbiter_if.sv
// gm_write_arbiter_if: bundles the two requester ports and the single-pixel
// write port toward the graphic manager.
//   req_valid/req_lock/req_col/req_row/req_color : per-port requests (index 0 = painter, 1 = overlay)
//   req_ack   : one-cycle accept pulse per port
//   grant     : one-hot current owner, 00 when idle
//   gm_ready  : graphic manager can take the presented pixel
//   write_pixel/pixel_col/pixel_row/bw_pixel_color : registered output stage
// Modports: master = requesters plus graphic manager side, slave = the arbiter.
interface gm_write_arbiter_if;
    import gm_pkg::*;

    logic [1:0]                 req_valid;
    logic [1:0]                 req_lock;
    logic [1:0][COL_WIDTH-1:0]  req_col;
    logic [1:0][ROW_WIDTH-1:0]  req_row;
    logic [1:0]                 req_color;
    logic [1:0]                 req_ack;
    logic [1:0]                 grant;
    logic                       gm_ready;
    logic                       write_pixel;
    logic [COL_WIDTH-1:0]       pixel_col;
    logic [ROW_WIDTH-1:0]       pixel_row;
    logic                       bw_pixel_color;

    modport master (
        output req_valid, req_lock, req_col, req_row, req_color, gm_ready,
        input  req_ack, grant, write_pixel, pixel_col, pixel_row, bw_pixel_color
    );

    modport slave (
        input  req_valid, req_lock, req_col, req_row, req_color, gm_ready,
        output req_ack, grant, write_pixel, pixel_col, pixel_row, bw_pixel_color
    );

endinterface

// File: rtl/gm_write_arbiter_counter.sv
// gm_write_arbiter_counter: saturating up-counter with synchronous reset.
//   clk   : clock
//   reset : synchronous, active-high clear
//   en    : count one step
//   count : current value, holds at MAX_VALUE-1
module gm_write_arbiter_counter #(
    parameter int MAX_VALUE = 17,
    parameter int WIDTH     = $clog2(MAX_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Saturation lets the owner of a locked burst keep counting without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != WIDTH'(MAX_VALUE - 1))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gm_write_arbiter.sv
// gm_write_arbiter: round-robin arbiter sharing the graphic manager pixel
// write port between the painter (port 0) and the overlay writer (port 1),
// with a per-owner burst limit, a burst lock and one registered output stage.
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   initialized : graphic manager ready; no new grants or accepts while low
//   bus         : gm_write_arbiter_if.slave (requests, acks, grant, output stage)
// Optional build macro GM_ARB_CLIP_EN: off-screen pixels are acked but not staged.
module gm_write_arbiter
    import gm_pkg::*;
#(
    parameter int MAX_BURST   = 16,
    parameter int BURST_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                initialized,
    gm_write_arbiter_if.slave   bus
);

    arb_state_t             state;
    arb_state_t             other_state;
    logic                   last_owner;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic                   owning;
    logic                   owner;
    logic                   own_valid;
    logic                   own_lock;
    logic                   other_valid;
    logic                   stage_free;
    logic                   limit_hit;
    logic                   accept;
    logic                   stage_load;
    logic                   switch_owner;

    assign owning      = (state != IDLE);
    assign owner       = (state == OWN1);
    assign other_state = owner ? OWN0 : OWN1;
    assign own_valid   = bus.req_valid[owner];
    assign own_lock    = bus.req_lock[owner];
    assign other_valid = bus.req_valid[!owner];
    assign stage_free  = !bus.write_pixel || bus.gm_ready;

    // The limit blocks the accept in the cycle it is reached, so a full burst
    // is exactly MAX_BURST writes before the hand-over cycle.
    assign limit_hit = (burst_cnt == BURST_WIDTH'(MAX_BURST)) && other_valid && !own_lock;
    assign accept    = owning && initialized && own_valid && stage_free && !limit_hit;

    // Every exit from an OWN state restarts the burst count for the next owner.
    assign switch_owner = owning && (initialized ? (!own_valid || limit_hit) : stage_free);

`ifdef GM_ARB_CLIP_EN
    assign stage_load = accept && pixel_in_range(bus.req_col[owner], bus.req_row[owner]);
`else
    assign stage_load = accept;
`endif

    assign bus.req_ack = {accept && owner, accept && !owner};
    assign bus.grant   = {state == OWN1, state == OWN0};

    gm_write_arbiter_counter #(
        .MAX_VALUE (MAX_BURST + 1),
        .WIDTH     (BURST_WIDTH)
    ) u_burst_cnt (
        .clk   (clk),
        .reset (reset || switch_owner),
        .en    (accept),
        .count (burst_cnt)
    );

    // Ownership FSM. IDLE spends one cycle choosing; the port that did not own
    // last wins a tie. Losing initialized waits for the staged pixel to drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (initialized && (bus.req_valid != 2'b00)) begin
                        if (bus.req_valid == 2'b11) begin
                            state <= last_owner ? OWN0 : OWN1;
                        end else begin
                            state <= bus.req_valid[0] ? OWN0 : OWN1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (!initialized) begin
                        if (stage_free) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end
                    end else if (!own_valid) begin
                        state      <= other_valid ? other_state : IDLE;
                        last_owner <= owner;
                    end else if (limit_hit) begin
                        state      <= other_state;
                        last_owner <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage: holds data until gm_ready, reloads in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.write_pixel    <= 1'b0;
            bus.pixel_col      <= '0;
            bus.pixel_row      <= '0;
            bus.bw_pixel_color <= 1'b0;
        end else if (stage_load) begin
            bus.write_pixel    <= 1'b1;
            bus.pixel_col      <= bus.req_col[owner];
            bus.pixel_row      <= bus.req_row[owner];
            bus.bw_pixel_color <= bus.req_color[owner];
        end else if (bus.gm_ready) begin
            bus.write_pixel    <= 1'b0;
        end
    end

endmodule
